// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: keypad entry and operation sequencing for the FPGA calculator.
// Builds signed operands from eBCD key events and runs the start/done handshake with the arithmetic unit.
module calc_entry_ctrl #(
    parameter int WIDTH        = 32,
    parameter int DIGITS       = 8,
    parameter int CALC_TIMEOUT = 1024
) (
    input  logic                    sw_clk,
    input  logic                    rst,
    input  logic [4:0]              eBCD,
    input  logic signed [WIDTH-1:0] ans,
    input  logic                    calc_done,
    input  logic                    calc_err,
    output logic signed [WIDTH-1:0] operand1,
    output logic signed [WIDTH-1:0] operand2,
    output logic [2:0]              operator,
    output logic                    calc_start,
    output logic signed [WIDTH-1:0] disp_value,
    output logic [1:0]              disp_mode,
    output logic [2:0]              state
);
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int TMO_W = $clog2(CALC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] DIG_MAX  = CNT_W'(DIGITS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CALC_TIMEOUT - 1);

    localparam logic [2:0] OP_EQ = 3'd0, OP_MUL = 3'd1, OP_DIV = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3, OP_SUB = 3'd4, OP_MOD = 3'd5;
    localparam logic [3:0] K_DIVMOD = 4'ha, K_MUL = 4'hb, K_ADDSUB = 4'hc;
    localparam logic [3:0] K_NEG = 4'hd, K_RECALL = 4'he, K_EQ = 4'hf;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_OPA    = 3'd1,
        S_OPB    = 3'd2,
        S_CALC   = 3'd3,
        S_RESULT = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    // toggle selects the alternate of a pending /,% or +,- pair instead of the first-press operator
    function automatic logic [2:0] sel_op(input logic [3:0] k, input logic [2:0] cur, input logic toggle);
        case (k)
            K_MUL:    sel_op = OP_MUL;
            K_DIVMOD: sel_op = (toggle && cur == OP_DIV) ? OP_MOD : OP_DIV;
            default:  sel_op = (toggle && cur == OP_ADD) ? OP_SUB : OP_ADD;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, last_q, last_d, ent_val;
    logic [WIDTH-1:0]        mag_q, mag_d, last_mag, dig_next;
    logic [2:0]              oper_q, oper_d, pend_q, pend_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    neg_q, neg_d, start_q, start_d, key_prev_q;
    logic                    key_evt, is_digit, is_op, has_entry;
    logic [3:0]              key;

    assign key       = eBCD[3:0];
    assign key_evt   = eBCD[4] & ~key_prev_q;
    assign is_digit  = (key <= 4'd9);
    assign is_op     = (key == K_DIVMOD) || (key == K_MUL) || (key == K_ADDSUB);
    assign has_entry = (cnt_q != '0) || neg_q;
    assign ent_val   = neg_q ? -$signed(mag_q) : $signed(mag_q);
    assign last_mag  = last_q[WIDTH-1] ? $unsigned(-last_q) : $unsigned(last_q);
    assign dig_next  = mag_q * WIDTH'(10) + WIDTH'(key);

    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            last_q     <= '0;
            mag_q      <= '0;
            oper_q     <= '0;
            pend_q     <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            neg_q      <= 1'b0;
            start_q    <= 1'b0;
            key_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            last_q     <= last_d;
            mag_q      <= mag_d;
            oper_q     <= oper_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            neg_q      <= neg_d;
            start_q    <= start_d;
            key_prev_q <= eBCD[4];
        end
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        last_d  = last_q;
        mag_d   = mag_q;
        oper_d  = oper_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        tmo_d   = tmo_q;
        start_d = 1'b0;

        // digit and sign edits are shared by both operand entry states
        if (key_evt && (state_q == S_OPA || state_q == S_OPB)) begin
            if (is_digit) begin
                if (cnt_q < DIG_MAX) begin
                    mag_d = dig_next;
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (key == K_NEG) begin
                neg_d = ~neg_q;
            end
        end

        case (state_q)
            S_IDLE: if (key_evt) begin
                if (is_digit) begin
                    mag_d = WIDTH'(key); neg_d = 1'b0; cnt_d = CNT_W'(1); state_d = S_OPA;
                end else if (key == K_RECALL) begin
                    mag_d = last_mag; neg_d = last_q[WIDTH-1]; cnt_d = DIG_MAX; state_d = S_OPA;
                end else if (key == K_NEG) begin
                    mag_d = '0; neg_d = 1'b1; cnt_d = '0; state_d = S_OPA;
                end
            end
            S_OPA: if (key_evt) begin
                if (is_op) begin
                    opa_d = ent_val; oper_d = sel_op(key, oper_q, 1'b0);
                    {mag_d, neg_d, cnt_d} = '0; state_d = S_OPB;
                end else if (key == K_EQ) begin
                    opa_d = ent_val; last_d = ent_val;
                    {mag_d, neg_d, cnt_d} = '0; state_d = S_RESULT;
                end
            end
            S_OPB: if (key_evt) begin
                if (is_op && !has_entry) begin
                    oper_d = sel_op(key, oper_q, 1'b1);
                end else if (key == K_RECALL) begin
                    mag_d = last_mag; neg_d = last_q[WIDTH-1]; cnt_d = DIG_MAX;
                end else if (is_op || key == K_EQ) begin
                    opb_d   = has_entry ? ent_val : opa_q;
                    pend_d  = (key == K_EQ) ? OP_EQ : sel_op(key, oper_q, 1'b0);
                    {mag_d, neg_d, cnt_d} = '0;
                    start_d = 1'b1;
                    tmo_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                tmo_d = tmo_q + 1'b1;
                if (calc_done && !start_q) begin
                    if (calc_err) begin
                        state_d = S_ERROR;
                    end else begin
                        last_d = ans;
                        opa_d  = ans;
                        if (pend_q == OP_EQ) begin
                            state_d = S_RESULT;
                        end else begin
                            oper_d = pend_q; {mag_d, neg_d, cnt_d} = '0; state_d = S_OPB;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end
            end
            S_RESULT: if (key_evt) begin
                if (is_digit) begin
                    mag_d = WIDTH'(key); neg_d = 1'b0; cnt_d = CNT_W'(1); state_d = S_OPA;
                end else if (is_op) begin
                    opa_d = last_q; oper_d = sel_op(key, oper_q, 1'b0);
                    {mag_d, neg_d, cnt_d} = '0; state_d = S_OPB;
                end else if (key == K_RECALL || key == K_NEG) begin
                    mag_d = last_mag; cnt_d = DIG_MAX; state_d = S_OPA;
                    neg_d = last_q[WIDTH-1] ^ (key == K_NEG);
                end
            end
            S_ERROR: if (key_evt && key == K_EQ) begin
                opa_d = '0; opb_d = '0; last_d = '0; oper_d = '0; pend_d = '0;
                {mag_d, neg_d, cnt_d} = '0; state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        disp_mode  = 2'd0;
        disp_value = '0;
        case (state_q)
            S_OPA:            begin disp_mode = 2'd1; disp_value = ent_val; end
            S_OPB:            begin disp_mode = 2'd1; disp_value = has_entry ? ent_val : opa_q; end
            S_CALC, S_RESULT: begin disp_mode = 2'd2; disp_value = last_q; end
            S_ERROR:          disp_mode = 2'd3;
            default:          ;
        endcase
    end

    assign operand1   = opa_q;
    assign operand2   = opb_q;
    assign operator   = oper_q;
    assign calc_start = start_q;
    assign state      = state_q;
endmodule

// File: doc/calc_entry_ctrl.md
# calc_entry_ctrl

Parametrised key-entry and sequencing controller for the FPGA calculator; successor to the fixed 8-digit entry logic in the calculator top level. It turns debounced extended-BCD key events from the keypad driver into signed operands and an operator code, hands them to the `calculate` arithmetic unit with a start/done handshake, and chains operations (`12+3*2=`). It drives a display value and mode for the segment driver path, and adds sign toggle, a last-answer recall, and a calculation watchdog.

## Interface
- `WIDTH`, 32: operand/result width, signed two's complement.
- `DIGITS`, 8: maximum decimal digits per entry; constraint 10^DIGITS-1 < 2^(WIDTH-1).
- `CALC_TIMEOUT`, 1024: `sw_clk` cycles allowed in CALC before forcing ERROR; must be ≥2.
- `sw_clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `eBCD`  in  5  keypad code: bit4 = key valid (level, held while pressed); [3:0] = key.
- `ans`  in  WIDTH  result from the arithmetic unit.
- `calc_done`  in  1  result valid; sampled only in CALC.
- `calc_err`  in  1  arithmetic error (div/mod by 0, overflow); qualified by `calc_done`.
- `operand1`  out  WIDTH  left operand A.
- `operand2`  out  WIDTH  right operand B.
- `operator`  out  3  0 `=`, 1 `*`, 2 `/`, 3 `+`, 4 `-`, 5 `%`.
- `calc_start`  out  1  one-cycle request pulse.
- `disp_value`  out  WIDTH  signed value to display.
- `disp_mode`  out  2  0 blank, 1 entry, 2 result, 3 error.
- `state`  out  3  current FSM state (debug).

## Operation
- Key map: 0-9 digit; `a` `/`↔`%`; `b` `*`; `c` `+`↔`-`; `d` sign toggle; `e` recall last answer; `f` `=`.
- A key event is one rising edge of `eBCD[4]`. Holding a key produces one event. The edge detector runs in every state, so a key held through CALC does not fire afterwards.
- Entry buffer: magnitude `buf`, sign `neg`, count `cnt`.
  - A digit with `cnt < DIGITS` does `buf = buf*10 + d`, `cnt++`.
  - Extra digits are ignored.
  - Entry value = `neg ? -buf : buf`.
  - `d` toggles `neg`.
- Operator keys: a first press selects `/` (`a`) or `+` (`c`). A repeat press while that operator is pending with no B digits toggles to `%` or `-`. `b` always selects `*`.
- States:
  - IDLE (0):
    - Digit → OPA with buf = digit.
    - `e` → OPA with entry = last answer.
    - `d` → OPA with buf = 0 and neg = 1.
    - All other keys are ignored.
  - OPA (1):
    - Digit, `d`: edit entry.
    - Operator key: A = entry, clear buffer, set operator → OPB.
    - `f`: last answer = A = entry → RESULT, with no calculation.
  - OPB (2):
    - Operator key with `cnt == 0` and `neg == 0`: modify operator only.
    - Digit, `d`: edit entry.
    - `e`: entry = last answer.
    - Operator key after entry: B = entry, remember the new operator as pending → CALC.
    - `f` after entry: B = entry, pending = `=` → CALC.
    - `f` with no entry: B = A → CALC.
  - CALC (3):
    - `calc_start` is high in the first cycle only.
    - `calc_done & ~calc_err`: last answer = A = `ans`. If pending is `=` → RESULT; otherwise operator = pending and buffer cleared → OPB.
    - `calc_done & calc_err` → ERROR.
    - Timeout → ERROR.
    - Keys are ignored.
  - RESULT (4):
    - Digit: new OPA entry.
    - Operator key: A = last answer → OPB.
    - `e`: OPA with entry = last answer.
    - `d`: OPA with entry = −last answer.
    - `f` is ignored.
  - ERROR (5): only `f` leaves, going to IDLE and clearing A, B, operator, buffer and last answer.
- Display:
  - IDLE: mode 0, value 0.
  - OPA/OPB: mode 1, value = entry. Just after an operator, value = A.
  - CALC/RESULT: mode 2, value = last answer.
  - ERROR: mode 3, value 0.

## Timing
- Reset (asynchronous, immediate) values: `state` = IDLE; `operand1`, `operand2`, `operator`, `disp_value` = 0; `calc_start` = 0; `disp_mode` = 0; buffer, last answer and edge-detect flop = 0.
- A key event is detected at edge k when `eBCD[4]` is 1 at edge k and was 0 at edge k-1. All resulting register and state updates are visible after edge k, a one-edge latency.
- `operand1`, `operand2` and `operator` are stable from the edge entering CALC until the edge leaving it.
- `calc_start` = 1 for exactly the first cycle in CALC.
- `calc_done` is honoured from the second CALC cycle onward. It is ignored outside CALC.
- If `calc_done` and timeout occur in the same cycle, `calc_done` wins. If `calc_err` and `calc_done` are both high, ERROR wins.
- Timeout counter:
  - Clears on entry to CALC.
  - Leaves CALC → ERROR when the count reaches `CALC_TIMEOUT`.
- Reset asserted during CALC aborts with no further `calc_start`.
- No key event is lost between states: the event that triggers a transition is fully consumed by it.

## Test plan
- Keys `1`,`2`,`c`,`3`,`f`, with the model returning 15 one cycle after start: one `calc_start`; operand1 = 12, operand2 = 3, operator = 3; then RESULT with disp_value = 15 and mode 2.
- Chain `1`,`2`,`c`,`3`,`b`,`2`,`f`, with the model returning A+B then A*B: the first CALC has pending `*`, after which operand1 = 15. The second CALC gives operand1 = 15, operand2 = 2, operator = 1, and final disp_value = 30.
- Operator toggle and sign: `9`,`a`,`a`,`d`,`4`,`f` → operator = 5 and operand2 = −4. Also 9 digits with DIGITS = 8: display shows the first 8 digits only.
- Hold `eBCD` = 5'h17 for 50 cycles: exactly one digit 7 is entered. A key held across CALC does not fire after CALC.
- Error paths:
  - `calc_err` with `calc_done` → mode 3.
  - No `calc_done` for `CALC_TIMEOUT` cycles → mode 3.
  - In ERROR, keys `5` and `c` are ignored; `f` → IDLE with all outputs 0.
- Answer recall and reset: after result 30, `e`,`c`,`1`,`f` → operand1 = 30, operand2 = 1. Asserting `rst` low mid-CALC immediately returns all outputs to reset values.
